pc_gen_mf: RTL and testbench
============================

// Module: pc_gen_mf
// PURPOSE
//  Multi-slot fetch PC generator. Emits one aligned fetch block of FETCH_W instructions per memory handshake.
//  Arbitrates redirects from commit, branch unit, early-jump decoder and predictor.
//  Keeps a redirect epoch counter so downstream fetch stages can discard stale responses.
//  Adds a debug halt FSM. Sits at the head of the frontend, driving the I-mem request port.
// PARAMETERS
//  XLEN      64      address width
//  BOOT_PC   'h0     PC loaded at reset
//  FETCH_W   4       instructions per fetch block; power of 2, >=1
//  EPOCH_W   3       redirect epoch counter width
// PORTS
//  clk_i                 in   1             clock
//  rst_ni                in   1             reset, asynchronous, active-low
//  comm_except_raised_i  in   1             commit exception/trap redirect
//  comm_except_pc_i      in   XLEN          exception target
//  bu_res_valid_i        in   1             branch resolution valid
//  bu_res_i              in   resolution_t  {pc, target, taken, mispredict}
//  bu_ready_o            out  1             always 1
//  early_jump_valid_i    in   1             decode-stage direct jump
//  early_jump_base_i     in   XLEN          jump PC
//  early_jump_offs_i     in   XLEN          jump immediate
//  early_jump_target_o   out  XLEN          base+offs (mod 2^XLEN), combinational
//  pred_taken_i          in   1             predictor: taken branch in current block
//  pred_slot_i           in   SLOT_W        slot of predicted branch
//  pred_target_i         in   XLEN          predicted target
//  halt_i                in   1             debug halt request (level)
//  halted_o              out  1             FSM in HALT
//  mem_ready_i           in   1             I-mem accepts request
//  valid_o               out  1             fetch request valid
//  pc_o                  out  XLEN          fetch PC (may be misaligned inside block)
//  slot_mask_o           out  FETCH_W       valid instruction slots of block
//  epoch_o               out  EPOCH_W       current redirect epoch
// BEHAVIOUR
//  - Reset: pc_o=BOOT_PC, state=BOOT, valid_o=0, epoch_o=0, halted_o=0.
//    bu_ready_o=1 always. Reset mid-operation aborts everything; outputs return to these values immediately.
//  - BLK=FETCH_W*4 bytes. off=pc_o[2+:SLOT_W]. seq_pc=(pc_o & ~(BLK-1))+BLK, wraps mod 2^XLEN.
//  - mispredict = bu_res_valid_i & bu_res_i.mispredict.
//    Redirect priority: except > mispredict > early jump > accepted block.
//  - Next PC:
//    - except: comm_except_pc_i.
//    - mispredict: target if taken, else bu_res_i.pc+4.
//    - early jump: early_jump_target_o.
//    - accepted block (valid_o & mem_ready_i): pred_target_i if pred_ok, else seq_pc.
//    - pred_ok = pred_taken_i & (pred_slot_i >= off); a predicted slot below off is ignored.
//  - pc_o updates on any redirect or accepted block; otherwise it holds.
//    valid_o & !mem_ready_i holds pc_o and slot_mask_o stable until accept or redirect.
//  - Lower-priority events in a redirect cycle are dropped, e.g. mispredict dropped under except.
//  - valid_o = (state==RUN) & !except & !mispredict & !early_jump_valid_i.
//  - epoch_o += 1 (wraps at 2^EPOCH_W) on except or mispredict, also in BOOT/HALT. Early jump does not change it.
//  - slot_mask_o[i] = (i>=off) & (!pred_ok | i<=pred_slot_i). Valid only when valid_o=1; value otherwise unspecified.
//  - FSM:
//    - BOOT -> RUN after 1 cycle.
//    - RUN -> HALT when halt_i & !(valid_o & !mem_ready_i); never abandons a pending request.
//    - HALT -> RUN when !halt_i. HALT: valid_o=0, halted_o=1.
//    - Redirects still update pc_o and epoch in BOOT and HALT.
//    - halt_i and a redirect in the same cycle: redirect applied, then HALT.
//  - FETCH_W=1: SLOT_W=1, off=0, slot_mask_o=1; behaviour degenerates to single-issue.
// STRUCTURE
//  - fetch_pkg: resolution_t (exists), FETCH_W default, SLOT_W=$clog2(FETCH_W) (1 when FETCH_W=1),
//    pc_gen_state_t {BOOT,RUN,HALT}.
//  - Sub-module fetch_slot_mask: combinational off/pred_slot -> slot_mask_o; reused by the fetch buffer.
//  - Top module holds the PC register, FSM, epoch counter and next-PC priority mux.
// TESTING (FETCH_W=4, BOOT_PC='h180, EPOCH_W=3)
//  1. Reset, mem_ready_i=1 -> cycle0 valid_o=0; then pc_o 'h180,'h190,'h1A0, slot_mask_o=4'b1111.
//  2. Except to 'h1008 -> valid_o=0 that cycle, epoch 0->1.
//     Next pc_o='h1008 with mask 4'b1100; then 'h1010.
//  3. At pc 'h1010: pred_taken_i=1, pred_slot_i=1, target 'h2000 -> mask 4'b0011, next pc 'h2000.
//     Repeat at pc 'h100C with pred_slot_i=1 -> prediction ignored, mask 4'b1000, next 'h1010.
//  4. mem_ready_i=0 for 3 cycles at pc 'h1A0 -> pc/mask/valid stable.
//     Add halt_i during the stall -> HALT only after the accept; halted_o=1, valid_o=0.
//  5. Except + mispredict + early jump in one cycle -> pc=except target, epoch +1 only.
//     Early jump alone (base 'h1A4, offs -8) -> pc='h19C, epoch unchanged.
//  6. Eight mispredicts -> epoch wraps 7->0.
//     pc_o='hFFFF_FFFF_FFFF_FFF0 sequential -> next pc_o=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared frontend types: branch resolution record, fetch geometry, PC generator states.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN  = 64;
    localparam int unsigned FETCH_W_DEF = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] target;
        logic                  taken;
        logic                  mispredict;
    } resolution_t;

    // Slot index width; a single-slot block still carries a 1-bit index.
    function automatic int unsigned slot_w(input int unsigned fw);
        return (fw > 1) ? $clog2(fw) : 1;
    endfunction

    localparam int unsigned SLOT_W_DEF = slot_w(FETCH_W_DEF);

    typedef logic [1:0] pc_gen_state_t;
    localparam pc_gen_state_t BOOT = 2'd0;
    localparam pc_gen_state_t RUN  = 2'd1;
    localparam pc_gen_state_t HALT = 2'd2;

endpackage

// File: rtl/fetch_slot_mask.sv
// Valid-slot mask of a fetch block: slots from the entry offset up to a taken predicted branch.
module fetch_slot_mask #(
    parameter int unsigned FETCH_W = 4,
    parameter int unsigned SLOT_W  = 2
) (
    input  logic [SLOT_W-1:0]  off_i,
    input  logic               pred_ok_i,
    input  logic [SLOT_W-1:0]  pred_slot_i,
    output logic [FETCH_W-1:0] slot_mask_o
);

    // Per-slot enable: at or after the entry slot, and not past a taken prediction.
    always_comb begin
        slot_mask_o = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            slot_mask_o[i] = (SLOT_W'(i) >= off_i) &
                             (~pred_ok_i | (SLOT_W'(i) <= pred_slot_i));
        end
    end

endmodule

// File: rtl/pc_gen_mf.sv
// Multi-slot fetch PC generator: redirect arbitration, PC register, epoch counter, halt FSM.
module pc_gen_mf
    import fetch_pkg::*;
#(
    parameter int unsigned          XLEN    = FETCH_XLEN,
    parameter logic [XLEN-1:0]      BOOT_PC = '0,
    parameter int unsigned          FETCH_W = FETCH_W_DEF,
    parameter int unsigned          EPOCH_W = 3,
    localparam int unsigned         SLOT_W  = slot_w(FETCH_W)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                comm_except_raised_i,
    input  logic [XLEN-1:0]     comm_except_pc_i,
    input  logic                bu_res_valid_i,
    input  resolution_t         bu_res_i,
    output logic                bu_ready_o,
    input  logic                early_jump_valid_i,
    input  logic [XLEN-1:0]     early_jump_base_i,
    input  logic [XLEN-1:0]     early_jump_offs_i,
    output logic [XLEN-1:0]     early_jump_target_o,
    input  logic                pred_taken_i,
    input  logic [SLOT_W-1:0]   pred_slot_i,
    input  logic [XLEN-1:0]     pred_target_i,
    input  logic                halt_i,
    output logic                halted_o,
    input  logic                mem_ready_i,
    output logic                valid_o,
    output logic [XLEN-1:0]     pc_o,
    output logic [FETCH_W-1:0]  slot_mask_o,
    output logic [EPOCH_W-1:0]  epoch_o
);

    localparam logic [XLEN-1:0] BLK = XLEN'(FETCH_W * 4);

    pc_gen_state_t       r_state;
    pc_gen_state_t       w_state_d;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     w_pc_d;
    logic [EPOCH_W-1:0]  r_epoch;
    logic [SLOT_W-1:0]   w_off;
    logic [XLEN-1:0]     w_seq_pc;
    logic                w_except;
    logic                w_mispredict;
    logic                w_accept;
    logic                w_pred_ok;

    if (FETCH_W == 1) begin : g_single
        assign w_off = '0;
    end else begin : g_multi
        assign w_off = r_pc[2 +: SLOT_W];
    end

    assign w_except     = comm_except_raised_i;
    assign w_mispredict = bu_res_valid_i & bu_res_i.mispredict;
    assign w_seq_pc     = (r_pc & ~(BLK - XLEN'(1))) + BLK;
    // A predicted branch before the entry slot belongs to code we skip over.
    assign w_pred_ok    = pred_taken_i & (pred_slot_i >= w_off);

    assign valid_o  = (r_state == RUN) & ~w_except & ~w_mispredict & ~early_jump_valid_i;
    assign w_accept = valid_o & mem_ready_i;

    assign bu_ready_o          = 1'b1;
    assign early_jump_target_o = early_jump_base_i + early_jump_offs_i;
    assign halted_o            = (r_state == HALT);
    assign pc_o                = r_pc;
    assign epoch_o             = r_epoch;

    fetch_slot_mask #(
        .FETCH_W (FETCH_W),
        .SLOT_W  (SLOT_W)
    ) u_slot_mask (
        .off_i       (w_off),
        .pred_ok_i   (w_pred_ok),
        .pred_slot_i (pred_slot_i),
        .slot_mask_o (slot_mask_o)
    );

    // Next-PC priority mux: except > mispredict > early jump > accepted block.
    always_comb begin
        w_pc_d = r_pc;
        if (w_except) begin
            w_pc_d = comm_except_pc_i;
        end else if (w_mispredict) begin
            w_pc_d = bu_res_i.taken ? XLEN'(bu_res_i.target) : XLEN'(bu_res_i.pc) + XLEN'(4);
        end else if (early_jump_valid_i) begin
            w_pc_d = early_jump_target_o;
        end else if (w_accept) begin
            w_pc_d = w_pred_ok ? pred_target_i : w_seq_pc;
        end
    end

    // Halt FSM; a stalled request is never abandoned to enter HALT.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            BOOT: w_state_d = RUN;
            RUN:  if (halt_i && !(valid_o && !mem_ready_i)) w_state_d = HALT;
            HALT: if (!halt_i) w_state_d = RUN;
            default: w_state_d = BOOT;
        endcase
    end

    // State, PC and epoch registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= BOOT;
            r_pc    <= BOOT_PC;
            r_epoch <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            if (w_except || w_mispredict) begin
                r_epoch <= r_epoch + EPOCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_mf.sv
// Directed bench for pc_gen_mf with FETCH_W=4, BOOT_PC='h180, EPOCH_W=3.
module tb_pc_gen_mf;
    import fetch_pkg::*;

    localparam int unsigned XLEN = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              comm_except_raised_i;
    logic [XLEN-1:0]   comm_except_pc_i;
    logic              bu_res_valid_i;
    resolution_t       bu_res_i;
    logic              bu_ready_o;
    logic              early_jump_valid_i;
    logic [XLEN-1:0]   early_jump_base_i;
    logic [XLEN-1:0]   early_jump_offs_i;
    logic [XLEN-1:0]   early_jump_target_o;
    logic              pred_taken_i;
    logic [1:0]        pred_slot_i;
    logic [XLEN-1:0]   pred_target_i;
    logic              halt_i;
    logic              halted_o;
    logic              mem_ready_i;
    logic              valid_o;
    logic [XLEN-1:0]   pc_o;
    logic [3:0]        slot_mask_o;
    logic [2:0]        epoch_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_ep;

    always #5 clk_i = ~clk_i;

    pc_gen_mf #(
        .XLEN    (XLEN),
        .BOOT_PC (64'h180),
        .FETCH_W (4),
        .EPOCH_W (3)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .comm_except_raised_i (comm_except_raised_i),
        .comm_except_pc_i     (comm_except_pc_i),
        .bu_res_valid_i       (bu_res_valid_i),
        .bu_res_i             (bu_res_i),
        .bu_ready_o           (bu_ready_o),
        .early_jump_valid_i   (early_jump_valid_i),
        .early_jump_base_i    (early_jump_base_i),
        .early_jump_offs_i    (early_jump_offs_i),
        .early_jump_target_o  (early_jump_target_o),
        .pred_taken_i         (pred_taken_i),
        .pred_slot_i          (pred_slot_i),
        .pred_target_i        (pred_target_i),
        .halt_i               (halt_i),
        .halted_o             (halted_o),
        .mem_ready_i          (mem_ready_i),
        .valid_o              (valid_o),
        .pc_o                 (pc_o),
        .slot_mask_o          (slot_mask_o),
        .epoch_o              (epoch_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        comm_except_raised_i = 1'b0;
        comm_except_pc_i     = '0;
        bu_res_valid_i       = 1'b0;
        bu_res_i             = '0;
        early_jump_valid_i   = 1'b0;
        early_jump_base_i    = '0;
        early_jump_offs_i    = '0;
        pred_taken_i         = 1'b0;
        pred_slot_i          = '0;
        pred_target_i        = '0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        halt_i      = 1'b0;
        mem_ready_i = 1'b1;
        idle();
        #12;
        chk("rst_pc", pc_o, 64'h180);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_epoch", {61'd0, epoch_o}, 64'd0);
        chk("rst_halted", {63'd0, halted_o}, 64'd0);
        chk("bu_ready", {63'd0, bu_ready_o}, 64'd1);
        rst_ni = 1'b1;
        #1;
        chk("boot_valid", {63'd0, valid_o}, 64'd0);
        tick();
        chk("run_valid", {63'd0, valid_o}, 64'd1);
        chk("run_pc0", pc_o, 64'h180);
        chk("run_mask0", {60'd0, slot_mask_o}, 64'hF);
        tick();
        chk("run_pc1", pc_o, 64'h190);
        tick();
        chk("run_pc2", pc_o, 64'h1A0);
        chk("run_mask2", {60'd0, slot_mask_o}, 64'hF);

        // Stall three cycles, halt requested mid-stall.
        mem_ready_i = 1'b0;
        #1;
        chk("stall0_pc", pc_o, 64'h1A0);
        chk("stall0_valid", {63'd0, valid_o}, 64'd1);
        tick();
        chk("stall1_pc", pc_o, 64'h1A0);
        chk("stall1_mask", {60'd0, slot_mask_o}, 64'hF);
        halt_i = 1'b1;
        tick();
        chk("stall2_pc", pc_o, 64'h1A0);
        chk("stall2_valid", {63'd0, valid_o}, 64'd1);
        chk("stall2_halted", {63'd0, halted_o}, 64'd0);
        mem_ready_i = 1'b1;
        #1;
        chk("accept_valid", {63'd0, valid_o}, 64'd1);
        tick();
        chk("halt_halted", {63'd0, halted_o}, 64'd1);
        chk("halt_valid", {63'd0, valid_o}, 64'd0);
        chk("halt_pc", pc_o, 64'h1B0);
        halt_i = 1'b0;
        tick();
        chk("resume_halted", {63'd0, halted_o}, 64'd0);
        chk("resume_valid", {63'd0, valid_o}, 64'd1);

        // Exception redirect into the middle of a block.
        comm_except_raised_i = 1'b1;
        comm_except_pc_i     = 64'h1008;
        #1;
        chk("exc_valid", {63'd0, valid_o}, 64'd0);
        chk("exc_epoch_pre", {61'd0, epoch_o}, 64'd0);
        tick();
        idle();
        #1;
        chk("exc_pc", pc_o, 64'h1008);
        chk("exc_epoch", {61'd0, epoch_o}, 64'd1);
        chk("exc_mask", {60'd0, slot_mask_o}, 64'hC);
        tick();
        chk("exc_seq_pc", pc_o, 64'h1010);

        // Taken prediction in slot 1.
        pred_taken_i  = 1'b1;
        pred_slot_i   = 2'd1;
        pred_target_i = 64'h2000;
        #1;
        chk("pred_mask", {60'd0, slot_mask_o}, 64'h3);
        tick();
        chk("pred_pc", pc_o, 64'h2000);
        idle();

        // Early jump to 'h100C, then a prediction below the entry slot.
        early_jump_valid_i = 1'b1;
        early_jump_base_i  = 64'h1000;
        early_jump_offs_i  = 64'hC;
        #1;
        chk("ej_target", early_jump_target_o, 64'h100C);
        chk("ej_valid", {63'd0, valid_o}, 64'd0);
        tick();
        idle();
        chk("ej_pc", pc_o, 64'h100C);
        chk("ej_epoch", {61'd0, epoch_o}, 64'd1);
        pred_taken_i  = 1'b1;
        pred_slot_i   = 2'd1;
        pred_target_i = 64'h2000;
        #1;
        chk("pred_ign_mask", {60'd0, slot_mask_o}, 64'h8);
        tick();
        chk("pred_ign_pc", pc_o, 64'h1010);
        idle();

        // All three redirects at once: exception wins, epoch +1 only.
        comm_except_raised_i  = 1'b1;
        comm_except_pc_i      = 64'h3000;
        bu_res_valid_i        = 1'b1;
        bu_res_i.target       = 64'h4000;
        bu_res_i.taken        = 1'b1;
        bu_res_i.mispredict   = 1'b1;
        early_jump_valid_i    = 1'b1;
        early_jump_base_i     = 64'h5000;
        #1;
        chk("combo_valid", {63'd0, valid_o}, 64'd0);
        tick();
        idle();
        chk("combo_pc", pc_o, 64'h3000);
        chk("combo_epoch", {61'd0, epoch_o}, 64'd2);

        // Early jump with a negative offset.
        early_jump_valid_i = 1'b1;
        early_jump_base_i  = 64'h1A4;
        early_jump_offs_i  = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        chk("ejneg_target", early_jump_target_o, 64'h19C);
        tick();
        idle();
        chk("ejneg_pc", pc_o, 64'h19C);
        chk("ejneg_epoch", {61'd0, epoch_o}, 64'd2);

        // Not-taken mispredict falls through to pc+4.
        bu_res_valid_i      = 1'b1;
        bu_res_i.pc         = 64'h500;
        bu_res_i.taken      = 1'b0;
        bu_res_i.mispredict = 1'b1;
        tick();
        idle();
        chk("mp_nt_pc", pc_o, 64'h504);
        chk("mp_nt_epoch", {61'd0, epoch_o}, 64'd3);
        chk("mp_nt_mask", {60'd0, slot_mask_o}, 64'hE);

        // Mispredict flag without resolution valid is ignored.
        bu_res_i.mispredict = 1'b1;
        bu_res_i.target     = 64'h7000;
        bu_res_i.taken      = 1'b1;
        #1;
        chk("mp_gated_valid", {63'd0, valid_o}, 64'd1);
        tick();
        idle();
        chk("mp_gated_pc", pc_o, 64'h510);

        // Eight back-to-back mispredicts wrap the epoch.
        exp_ep              = 3'd3;
        bu_res_valid_i      = 1'b1;
        bu_res_i.target     = 64'hFFFF_FFFF_FFFF_FFF0;
        bu_res_i.taken      = 1'b1;
        bu_res_i.mispredict = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ep = exp_ep + 3'd1;
            chk($sformatf("mp_wrap_epoch%0d", k), {61'd0, epoch_o}, {61'd0, exp_ep});
        end
        idle();
        #1;
        chk("top_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("top_mask", {60'd0, slot_mask_o}, 64'hF);
        tick();
        chk("wrap_pc", pc_o, 64'h0);

        // Redirect while halted still moves pc and epoch.
        halt_i = 1'b1;
        tick();
        chk("halt2_halted", {63'd0, halted_o}, 64'd1);
        chk("halt2_pc", pc_o, 64'h10);
        comm_except_raised_i = 1'b1;
        comm_except_pc_i     = 64'h800;
        tick();
        idle();
        chk("halt_exc_pc", pc_o, 64'h800);
        chk("halt_exc_epoch", {61'd0, epoch_o}, 64'd4);
        chk("halt_exc_halted", {63'd0, halted_o}, 64'd1);
        chk("halt_exc_valid", {63'd0, valid_o}, 64'd0);

        // Asynchronous reset mid-cycle.
        halt_i = 1'b0;
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_pc", pc_o, 64'h180);
        chk("arst_epoch", {61'd0, epoch_o}, 64'd0);
        chk("arst_valid", {63'd0, valid_o}, 64'd0);
        chk("arst_halted", {63'd0, halted_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
